// File: rtl/ip_fp_pkg.sv
// Shared definitions for the ip_fp_* float blocks: rounding modes, status bits
// and the FP-to-integer converter state encoding.
package ip_fp_pkg;

    localparam logic [2:0] RND_RNE = 3'd0;
    localparam logic [2:0] RND_RTZ = 3'd1;
    localparam logic [2:0] RND_RUP = 3'd2;
    localparam logic [2:0] RND_RDN = 3'd3;
    localparam logic [2:0] RND_RNA = 3'd4;

    localparam int ST_INVALID = 0;
    localparam int ST_INEXACT = 1;
    localparam int ST_ZERO    = 2;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_SHIFT = 2'd1,
        S_ROUND = 2'd2,
        S_DONE  = 2'd3
    } fp2int_state_e;

endpackage

// File: rtl/ip_fp_unpack.sv
// Combinational float unpacker: field split, hidden bit, unbiased exponent
// (denormals use 1-bias) and zero/inf/nan classification.
module ip_fp_unpack #(
    parameter int P_EXP  = 5,
    parameter int P_FRAC = 10,
    parameter int P_BIAS = 15,
    parameter int P_WORD = 1 + P_EXP + P_FRAC
) (
    input  logic [P_WORD-1:0]       a,
    output logic                    sign,
    output logic signed [P_EXP+1:0] exp_unb,
    output logic [P_FRAC:0]         mant,
    output logic                    is_zero,
    output logic                    is_inf,
    output logic                    is_nan
);

    logic [P_EXP-1:0]  exp_f;
    logic [P_FRAC-1:0] frac_f;
    logic              exp_zero;
    logic              exp_ones;
    logic              frac_zero;

    assign sign      = a[P_WORD-1];
    assign exp_f     = a[P_WORD-2 -: P_EXP];
    assign frac_f    = a[P_FRAC-1:0];
    assign exp_zero  = (exp_f == '0);
    assign exp_ones  = (exp_f == '1);
    assign frac_zero = (frac_f == '0);

    assign mant    = {~exp_zero, frac_f};
    assign exp_unb = exp_zero ? (P_EXP+2)'(1 - P_BIAS)
                              : $signed({2'b00, exp_f}) - (P_EXP+2)'(P_BIAS);

    assign is_zero = exp_zero & frac_zero;
    assign is_inf  = exp_ones & frac_zero;
    assign is_nan  = exp_ones & ~frac_zero;

endmodule

// File: rtl/ip_fp2int.sv
// Sequential float-to-signed-integer converter: one-bit-per-cycle denormalising
// shifter with guard/sticky, mode-selectable rounding and saturation.
module ip_fp2int
    import ip_fp_pkg::*;
#(
    parameter int P_EXP  = 5,
    parameter int P_FRAC = 10,
    parameter int P_BIAS = 15,
    parameter int P_WORD = 1 + P_EXP + P_FRAC,
    parameter int P_INT  = 16
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [P_WORD-1:0] a,
    input  logic [2:0]        rnd,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [P_INT-1:0]  z,
    output logic [7:0]        status
);

    // Handshake: a transfer happens on a rising edge where valid && ready; the
    // producer holds its data until then, and at most one operation is in flight.

    localparam int CW = $clog2(P_INT + P_FRAC + 3);
    localparam logic [P_INT-1:0] INT_MAX = {1'b0, {(P_INT-1){1'b1}}};
    localparam logic [P_INT-1:0] INT_MIN = {1'b1, {(P_INT-1){1'b0}}};
    localparam logic [P_INT:0]   MAG_POS_MAX = {2'b00, {(P_INT-1){1'b1}}};
    localparam logic [P_INT:0]   MAG_NEG_MAX = {2'b01, {(P_INT-1){1'b0}}};

    fp2int_state_e state, state_d;

    logic                    u_sign, u_zero, u_inf, u_nan;
    logic signed [P_EXP+1:0] u_exp;
    logic [P_FRAC:0]         u_mant;

    logic             sign_q, left_q, g_q, s_q;
    logic [2:0]       rnd_q;
    logic [P_INT-1:0] mag_q;
    logic [CW-1:0]    cnt_q;

    int               e_i, n_i;
    logic             frac_zero, ovf, special, shift_left;
    logic [P_INT-1:0] spec_z;
    logic [7:0]       spec_st;

    logic             inc, ovf_r;
    logic [P_INT:0]   mag_r;
    logic [P_INT-1:0] z_rnd;
    logic [7:0]       st_rnd;

    ip_fp_unpack #(
        .P_EXP (P_EXP),
        .P_FRAC(P_FRAC),
        .P_BIAS(P_BIAS),
        .P_WORD(P_WORD)
    ) u_unpack (
        .a      (a),
        .sign   (u_sign),
        .exp_unb(u_exp),
        .mant   (u_mant),
        .is_zero(u_zero),
        .is_inf (u_inf),
        .is_nan (u_nan)
    );

    assign in_ready  = (state == S_IDLE);
    assign out_valid = (state == S_DONE);

    // Classification of the operand presented in IDLE.
    always_comb begin
        e_i        = u_exp;
        frac_zero  = (a[P_FRAC-1:0] == '0);
        // -2^(P_INT-1) is the one exactly representable value at E == P_INT-1.
        ovf        = (e_i > P_INT - 1) || ((e_i == P_INT - 1) && !(u_sign && frac_zero));
        special    = u_nan | u_inf | u_zero | ovf;
        shift_left = (e_i >= P_FRAC);
        if (shift_left)
            n_i = e_i - P_FRAC;
        else if (P_FRAC - e_i > P_FRAC + 2)
            n_i = P_FRAC + 2;
        else
            n_i = P_FRAC - e_i;

        spec_z  = INT_MAX;
        spec_st = 8'h00;
        if (u_zero) begin
            spec_z           = '0;
            spec_st[ST_ZERO] = 1'b1;
        end else begin
            spec_st[ST_INVALID] = 1'b1;
            if (!u_nan && u_sign)
                spec_z = INT_MIN;
        end
    end

    always_comb begin
        case (rnd_q)
            RND_RTZ: inc = 1'b0;
            RND_RUP: inc = (g_q | s_q) & ~sign_q;
            RND_RDN: inc = (g_q | s_q) & sign_q;
            RND_RNA: inc = g_q;
            default: inc = g_q & (s_q | mag_q[0]);
        endcase
        mag_r  = {1'b0, mag_q} + {{P_INT{1'b0}}, inc};
        ovf_r  = sign_q ? (mag_r > MAG_NEG_MAX) : (mag_r > MAG_POS_MAX);
        z_rnd  = sign_q ? -mag_r[P_INT-1:0] : mag_r[P_INT-1:0];
        st_rnd = 8'h00;
        if (ovf_r) begin
            z_rnd              = sign_q ? INT_MIN : INT_MAX;
            st_rnd[ST_INVALID] = 1'b1;
        end else begin
            st_rnd[ST_INEXACT] = g_q | s_q;
            st_rnd[ST_ZERO]    = (z_rnd == '0);
        end
    end

    always_comb begin
        state_d = state;
        case (state)
            S_IDLE: begin
                if (in_valid) begin
                    if (special)
                        state_d = S_DONE;
                    else if (n_i == 0)
                        state_d = S_ROUND;
                    else
                        state_d = S_SHIFT;
                end
            end
            S_SHIFT: if (cnt_q == CW'(1)) state_d = S_ROUND;
            S_ROUND: state_d = S_DONE;
            S_DONE:  if (out_ready) state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            state <= S_IDLE;
        else
            state <= state_d;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sign_q <= 1'b0;
            left_q <= 1'b0;
            g_q    <= 1'b0;
            s_q    <= 1'b0;
            rnd_q  <= RND_RNE;
            mag_q  <= '0;
            cnt_q  <= '0;
            z      <= '0;
            status <= 8'h00;
        end else begin
            case (state)
                S_IDLE: begin
                    if (in_valid) begin
                        sign_q <= u_sign;
                        rnd_q  <= rnd;
                        left_q <= shift_left;
                        mag_q  <= {{(P_INT-P_FRAC-1){1'b0}}, u_mant};
                        g_q    <= 1'b0;
                        s_q    <= 1'b0;
                        cnt_q  <= CW'(n_i);
                        if (special) begin
                            z      <= spec_z;
                            status <= spec_st;
                        end
                    end
                end
                S_SHIFT: begin
                    if (left_q) begin
                        mag_q <= mag_q << 1;
                    end else begin
                        mag_q <= mag_q >> 1;
                        g_q   <= mag_q[0];
                        s_q   <= s_q | g_q;
                    end
                    cnt_q <= cnt_q - CW'(1);
                end
                S_ROUND: begin
                    z      <= z_rnd;
                    status <= st_rnd;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_ip_fp2int.sv
// Directed bench for ip_fp2int (FP16 -> int16): rounding modes, saturation,
// denormals/zero, latency, backpressure and reset during a shift.
module tb_ip_fp2int;
    import ip_fp_pkg::*;

    typedef struct {
        logic [15:0] a;
        logic [2:0]  rnd;
        logic [15:0] z;
        logic [7:0]  st;
        int          lat;
    } vec_t;

    logic        clk;
    logic        rst_n;
    logic        in_valid;
    logic        in_ready;
    logic [15:0] a;
    logic [2:0]  rnd;
    logic        out_valid;
    logic        out_ready;
    logic [15:0] z;
    logic [7:0]  status;

    int tests = 0;
    int fails = 0;

    ip_fp2int dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .in_valid (in_valid),
        .in_ready (in_ready),
        .a        (a),
        .rnd      (rnd),
        .out_valid(out_valid),
        .out_ready(out_ready),
        .z        (z),
        .status   (status)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // Drives one operand, measures latency (edges after accept), captures result.
    task automatic run_op(input logic [15:0] av, input logic [2:0] rv, input bit release_now,
                          output logic [15:0] zo, output logic [7:0] so, output int lat);
        int guard;
        lat = -1;
        @(negedge clk);
        a = av;
        rnd = rv;
        in_valid = 1'b1;
        guard = 0;
        while (!in_ready && guard < 50) begin
            @(negedge clk);
            guard++;
        end
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        a = 16'($urandom_range(0, 65535));
        rnd = 3'($urandom_range(0, 7));
        for (int k = 1; k <= 100; k++) begin
            @(negedge clk);
            if (out_valid) begin
                lat = k;
                break;
            end
        end
        zo = z;
        so = status;
        if (release_now) begin
            out_ready = 1'b1;
            @(posedge clk);
            #1;
            out_ready = 1'b0;
        end
    endtask

    task automatic test_reset();
        @(negedge clk);
        tests++;
        if (in_ready !== 1'b1 || out_valid !== 1'b0 || z !== 16'h0000 || status !== 8'h00) begin
            fails++;
            $display("FAIL reset_values: in_ready=%b out_valid=%b z=%h status=%h, required 1 0 0000 00",
                     in_ready, out_valid, z, status);
        end
    endtask

    task automatic run_table(input string name, input vec_t v[$]);
        logic [15:0] zo;
        logic [7:0]  so;
        int          lat;
        foreach (v[i]) begin
            run_op(v[i].a, v[i].rnd, 1'b1, zo, so, lat);
            tests++;
            if (zo !== v[i].z || so !== v[i].st || lat != v[i].lat) begin
                fails++;
                $display("FAIL %s[%0d] a=%h rnd=%0d: z=%h status=%h lat=%0d, required z=%h status=%h lat=%0d",
                         name, i, v[i].a, v[i].rnd, zo, so, lat, v[i].z, v[i].st, v[i].lat);
            end
        end
    endtask

    task automatic test_round_modes();
        vec_t v[$];
        v.push_back('{16'h3E00, RND_RNE, 16'h0002, 8'h02, 12});
        v.push_back('{16'h3E00, RND_RTZ, 16'h0001, 8'h02, 12});
        v.push_back('{16'h3E00, 3'd7,    16'h0002, 8'h02, 12});
        v.push_back('{16'h4100, RND_RNE, 16'h0002, 8'h02, 11});
        v.push_back('{16'h4100, RND_RNA, 16'h0003, 8'h02, 11});
        v.push_back('{16'hC100, RND_RUP, 16'hFFFE, 8'h02, 11});
        v.push_back('{16'hC100, RND_RDN, 16'hFFFD, 8'h02, 11});
        v.push_back('{16'h5A00, RND_RNE, 16'h00C0, 8'h00, 5});
        v.push_back('{16'h6400, RND_RNE, 16'h0400, 8'h00, 2});
        run_table("round", v);
    endtask

    task automatic test_saturation();
        vec_t v[$];
        v.push_back('{16'hF800, RND_RNE, 16'h8000, 8'h00, 7});
        v.push_back('{16'h7800, RND_RNE, 16'h7FFF, 8'h01, 1});
        v.push_back('{16'h7C00, RND_RNE, 16'h7FFF, 8'h01, 1});
        v.push_back('{16'h7E00, RND_RNE, 16'h7FFF, 8'h01, 1});
        v.push_back('{16'hFC00, RND_RNE, 16'h8000, 8'h01, 1});
        v.push_back('{16'hFE00, RND_RTZ, 16'h7FFF, 8'h01, 1});
        v.push_back('{16'hF801, RND_RNE, 16'h8000, 8'h01, 1});
        run_table("sat", v);
    endtask

    task automatic test_denormal_zero();
        vec_t v[$];
        v.push_back('{16'h0001, RND_RNE, 16'h0000, 8'h06, 14});
        v.push_back('{16'h0001, RND_RUP, 16'h0001, 8'h02, 14});
        v.push_back('{16'h8001, RND_RDN, 16'hFFFF, 8'h02, 14});
        v.push_back('{16'h8000, RND_RNE, 16'h0000, 8'h04, 1});
        v.push_back('{16'h0000, RND_RTZ, 16'h0000, 8'h04, 1});
        run_table("denorm", v);
    endtask

    task automatic test_backpressure();
        bit seen;
        @(negedge clk);
        a = 16'h3E00;
        rnd = RND_RNE;
        in_valid = 1'b1;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        a = 16'h7C00;
        @(negedge clk);
        tests++;
        if (in_ready !== 1'b0) begin
            fails++;
            $display("FAIL busy_in_ready: in_ready=%b, required 0", in_ready);
        end
        seen = 1'b0;
        for (int k = 0; k < 100 && !seen; k++) begin
            if (out_valid) seen = 1'b1;
            else @(negedge clk);
        end
        tests++;
        if (!seen) begin
            fails++;
            $display("FAIL bp_out_valid: out_valid=0 after 100 cycles, required 1");
        end
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            tests++;
            if (z !== 16'h0002 || status !== 8'h02 || in_ready !== 1'b0 || out_valid !== 1'b1) begin
                fails++;
                $display("FAIL bp_hold[%0d]: z=%h status=%h in_ready=%b out_valid=%b, required 0002 02 0 1",
                         i, z, status, in_ready, out_valid);
            end
        end
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        out_ready = 1'b0;
        @(negedge clk);
        tests++;
        if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
            fails++;
            $display("FAIL bp_release: in_ready=%b out_valid=%b, required 1 0", in_ready, out_valid);
        end
    endtask

    task automatic test_reset_mid_shift();
        logic [15:0] zo;
        logic [7:0]  so;
        int          lat;
        @(negedge clk);
        a = 16'h3C00;
        rnd = RND_RTZ;
        in_valid = 1'b1;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        repeat (3) @(negedge clk);
        #1;
        rst_n = 1'b0;
        #1;
        tests++;
        if (in_ready !== 1'b1 || out_valid !== 1'b0 || z !== 16'h0000 || status !== 8'h00) begin
            fails++;
            $display("FAIL reset_mid_shift: in_ready=%b out_valid=%b z=%h status=%h, required 1 0 0000 00",
                     in_ready, out_valid, z, status);
        end
        @(negedge clk);
        rst_n = 1'b1;
        run_op(16'hC100, RND_RNE, 1'b1, zo, so, lat);
        tests++;
        if (zo !== 16'hFFFE || so !== 8'h02 || lat != 11) begin
            fails++;
            $display("FAIL after_reset: z=%h status=%h lat=%0d, required FFFE 02 11", zo, so, lat);
        end
    endtask

    initial begin
        rst_n = 1'b0;
        in_valid = 1'b0;
        out_ready = 1'b0;
        a = '0;
        rnd = RND_RNE;
        repeat (3) @(posedge clk);
        test_reset();
        @(negedge clk);
        rst_n = 1'b1;
        test_reset();
        test_round_modes();
        test_saturation();
        test_denormal_zero();
        test_backpressure();
        test_reset_mid_shift();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/ip_fp2int.md
# ip_fp2int

- Sequential FP-to-signed-integer converter: the exit path from the `ip_fp_*` float domain back to integer datapaths.
- Accepts one IEEE-style float (same `P_EXP`/`P_FRAC`/`P_BIAS` format as the adder), unpacks it, denormalises it with an iterative one-bit-per-cycle shifter that collects guard/sticky, rounds per `rnd`, and returns a saturated two's-complement integer.
- Uses a valid/ready handshake on both sides and holds one operation in flight at a time.

## Interface
Parameters:
- `P_EXP`, 5: exponent width
- `P_FRAC`, 10: stored fraction width
- `P_BIAS`, 15: exponent bias
- `P_WORD`, 1+P_EXP+P_FRAC: float word width
- `P_INT`, 16: output integer width; must satisfy P_INT > P_FRAC+1

Ports:
- `clk`  in  1  clock; single clock domain
- `rst_n`  in  1  asynchronous, active-low reset
- `in_valid`  in  1  operand valid
- `in_ready`  out  1  converter idle and able to accept
- `a`  in  P_WORD  float operand, {sign, exp, frac}
- `rnd`  in  3  rounding mode, sampled with `a`: 0 RNE, 1 RTZ, 2 RUP (+inf), 3 RDN (−inf), 4 RNA; 5–7 behave as RNE
- `out_valid`  out  1  result valid
- `out_ready`  in  1  consumer accepts the result
- `z`  out  P_INT  signed integer result
- `status`  out  8  [0] invalid, [1] inexact, [2] zero result, [7:3] always 0

## Operation
- States: IDLE, SHIFT, ROUND, DONE.
- IDLE (`in_ready`=1)
  - Accept when `in_valid` is high. Register sign, `rnd`, mantissa m={hidden,frac} (hidden=0 when exp==0), and E = exp−P_BIAS (1−P_BIAS when exp==0).
- Classification at accept:
  - NaN, Inf, or overflow → DONE with a saturated result.
  - Overflow means E > P_INT−1, or E == P_INT−1 except the exact case −2^(P_INT−1) (sign=1, frac=0).
  - ±0 → DONE with z=0 and status=0x04.
  - Otherwise go to SHIFT with count n.
    - Right shift when E < P_FRAC: n = min(P_FRAC−E, P_FRAC+2).
    - Left shift when E ≥ P_FRAC: n = E−P_FRAC.
    - n==0 goes straight to ROUND.
- SHIFT
  - One bit per cycle; the counter decrements each cycle and the block exits to ROUND when it reaches 0.
  - Right shift: the new guard is the bit shifted out; the old guard ORs into sticky.
  - Left shift: zeros enter at the LSB; guard and sticky stay 0.
  - Magnitude register is P_INT bits, plus separate guard and sticky bits.
- ROUND: increment the magnitude when:
  - RNE: g && (s || lsb)
  - RTZ: never
  - RUP: (g||s) && !sign
  - RDN: (g||s) && sign
  - RNA: g
- ROUND outputs:
  - inexact = g||s.
  - Negate the magnitude when sign=1.
  - Post-round overflow check: magnitude > 2^(P_INT−1)−1 for positive, > 2^(P_INT−1) for negative → saturate with status=0x01.
  - status[2] = (z==0).
- Saturation values:
  - Positive overflow, +Inf, and NaN → 2^(P_INT−1)−1.
  - Negative overflow and −Inf → −2^(P_INT−1).
  - invalid=1, inexact=0.
- DONE: `out_valid`=1. `z` and `status` are held stable until `out_ready`; the block returns to IDLE on the next edge.

## Timing
- Reset values: state IDLE, `in_ready`=1, `out_valid`=0, `z`=0, `status`=0.
- Accept edge = cycle 0. For normal operands `out_valid` rises n+2 cycles later. For special cases (NaN, Inf, overflow, zero) it rises 1 cycle later.
- `in_ready` is 0 in every state except IDLE. After the output handshake, `in_ready` returns to 1 on the following cycle, so there is no back-to-back overlap.
- `a` and `rnd` may change freely after the accept edge.
- `out_ready` is ignored outside DONE. Holding it high continuously gives a 1-cycle DONE.
- Reset asserted in any state, including mid-SHIFT, immediately forces the reset values and discards the operation. After release the block starts in IDLE.

## Structure
- Shared package `ip_fp_pkg`:
  - rounding-mode constants (`RND_RNE` … `RND_RNA`)
  - status bit indices
  - the state enum
- Sub-module `ip_fp_unpack` (combinational):
  - field split and hidden-bit insertion
  - denormal exponent fix-up
  - classification flags (zero/inf/nan)
  - reusable by `ip_fp_addsub` and future FP blocks.
- Top holds the FSM, shift counter, magnitude/guard/sticky registers, rounding, and saturation.

## Test plan
All cases use default parameters (FP16 → int16).
- 0x3E00 (1.5), RNE → z=2, status=0x02, `out_valid` 12 cycles after accept. RTZ → z=1.
- 0x4100 (2.5): RNE → 2, RNA → 3, status 0x02. 0xC100 (−2.5): RUP → 0xFFFE, RDN → 0xFFFD.
- 0xF800 (−32768.0) → 0x8000, status 0x00, latency 7. 0x7800 (32768.0) → 0x7FFF, status 0x01. 0x7C00 and 0x7E00 → 0x7FFF, status 0x01, latency 1.
- 0x0001 (smallest denormal): RNE → 0, status 0x06, latency 14 (shift capped at 12). RUP → 1, status 0x02.
- 0x8000 (−0) → z=0, status 0x04, latency 1. 0x6400 (1024.0) → 0x0400, status 0x00, latency 2 (n=0).
- `out_ready` low for 5 cycles in DONE → `z`/`status` stable and `in_ready`=0. Then `rst_n` pulsed mid-SHIFT → all outputs at reset values at once, and the next operand converts correctly.
